mem_rd_arbiter: RTL

- Shares the single memory read port (addra/douta) between two requesters.
  - Port 0: the multi-cycle CPU, which issues instruction and data fetches.
  - Port 1: the LCD/debug monitor, which reads memory words for display.
- One read transaction is in flight at a time.
- Port 0 has fixed priority; a starvation counter guarantees that port 1 eventually gets a grant.
- Sits between the CPU datapath / debug monitor and the memory instance. It runs on the memory read clock.

---
 rtl/mem_rd_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one memory read port between the CPU (port 0) and the
// LCD/debug monitor (port 1).
// Port 0 has fixed priority. A starvation counter forces a grant to port 1
// after MAX_WAIT consecutive blocked cycles.
// Only one read is in flight at a time.
// Optional feature: define MEM_RD_ARBITER_STATS_EN to add grant counters and a
// stall peak register for display on the LCD second line.
module mem_rd_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
`ifdef MEM_RD_ARBITER_STATS_EN
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1,
    output logic [7:0]    stall_max,
`endif
    output logic          busy
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
    localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic [2:0]    r_lat_cnt;
    logic [7:0]    r_wait_cnt;
    logic [AW-1:0] r_mem_addr;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_busy;

    logic          w_elig0;
    logic          w_elig1;
    logic          w_starved;
    logic          w_grant;
    logic          w_win1;
    logic          w_grant1;
    logic [7:0]    w_wait_next;

    // A requester whose ack is high this cycle is not eligible again until it
    // has seen the ack, so a held level request cannot double-issue.
    assign w_elig0   = req0 && !r_ack0;
    assign w_elig1   = req1 && !r_ack1;
    assign w_starved = (r_wait_cnt == MAX_W);
    assign w_grant   = (r_state == IDLE) && (w_elig0 || w_elig1);
    assign w_win1    = w_elig1 && (w_starved || !w_elig0);
    assign w_grant1  = w_grant && w_win1;

    // Next starvation count: clears on a port 1 grant or when port 1 is idle,
    // otherwise counts blocked cycles (WAIT included) and saturates.
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!req1 || w_grant1) begin
            w_wait_next = 8'd0;
        end else if (r_wait_cnt < MAX_W) begin
            w_wait_next = r_wait_cnt + 8'd1;
        end
    end

    // Arbitration FSM: grant in IDLE, count down the memory latency in WAIT,
    // then capture the read data for the owner and pulse its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_lat_cnt  <= 3'd0;
            r_wait_cnt <= 8'd0;
            r_mem_addr <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_wait_cnt <= w_wait_next;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_mem_addr <= w_win1 ? addr1 : addr0;
                        r_owner    <= w_win1;
                        r_lat_cnt  <= LAT_INIT;
                        r_busy     <= 1'b1;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        if (r_owner) begin
                            r_rdata1 <= mem_rdata;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= mem_rdata;
                            r_ack0   <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = r_busy;

`ifdef MEM_RD_ARBITER_STATS_EN
    logic [15:0] r_gnt_cnt0;
    logic [15:0] r_gnt_cnt1;
    logic [7:0]  r_stall_max;

    // Per-port grant counters (wrapping) and the peak starvation count seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_cnt0  <= 16'd0;
            r_gnt_cnt1  <= 16'd0;
            r_stall_max <= 8'd0;
        end else begin
            if (w_grant && !w_win1) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
            end
            if (w_grant1) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
            end
            if (w_wait_next > r_stall_max) begin
                r_stall_max <= w_wait_next;
            end
        end
    end

    assign gnt_cnt0  = r_gnt_cnt0;
    assign gnt_cnt1  = r_gnt_cnt1;
    assign stall_max = r_stall_max;
`endif

endmodule
